// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU opcodes, multiply/divide FSM states and datapath width.
package pipe_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_ADDU  = 5'd1,
        OP_SUB   = 5'd2,
        OP_SUBU  = 5'd3,
        OP_AND   = 5'd4,
        OP_OR    = 5'd5,
        OP_XOR   = 5'd6,
        OP_NOR   = 5'd7,
        OP_SLT   = 5'd8,
        OP_SLTU  = 5'd9,
        OP_SLL   = 5'd10,
        OP_SRL   = 5'd11,
        OP_SRA   = 5'd12,
        OP_SLLV  = 5'd13,
        OP_SRLV  = 5'd14,
        OP_SRAV  = 5'd15,
        OP_LUI   = 5'd16,
        OP_MULT  = 5'd17,
        OP_MULTU = 5'd18,
        OP_DIV   = 5'd19,
        OP_DIVU  = 5'd20,
        OP_MFHI  = 5'd21,
        OP_MFLO  = 5'd22,
        OP_MTHI  = 5'd23,
        OP_MTLO  = 5'd24
    } alu_op_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Any opcode that touches HI/LO or the multiply/divide unit.
    function automatic logic is_hilo_op(alu_op_t op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                          OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
    endfunction

    // Opcodes that hand work to the multiply/divide unit and write no GPR.
    function automatic logic is_md_issue(alu_op_t op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, EX/MEM outputs and hazard signals of the execute stage.
interface ex_stage_if #(
    parameter int XLEN = pipe_pkg::XLEN
);
    import pipe_pkg::*;

    logic            valid_in;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] gprA_in;
    logic [XLEN-1:0] gprB_in;
    logic [XLEN-1:0] ext_in;
    logic [4:0]      shamt_in;
    logic [4:0]      rd_in;
    logic [4:0]      rt_in;
    alu_op_t         ALUop_in;
    logic            ALUsrc_in;
    logic            AluShift_in;
    logic            RegDst_in;
    logic            Branch_in;
    logic            nbranch_in;
    logic            Mwrite_in;
    logic            Mread_in;
    logic            RegWrite_in;
    logic            MtoR_in;

    logic            stall;
    logic            do_flush;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] res_out;
    logic [XLEN-1:0] stdata_out;
    logic [4:0]      dst_out;
    logic            Mwrite_out;
    logic            Mread_out;
    logic            RegWrite_out;
    logic            MtoR_out;

    modport master (
        output valid_in, pc_in, gprA_in, gprB_in, ext_in, shamt_in, rd_in, rt_in,
               ALUop_in, ALUsrc_in, AluShift_in, RegDst_in, Branch_in, nbranch_in,
               Mwrite_in, Mread_in, RegWrite_in, MtoR_in,
        input  stall, do_flush, br_target, res_out, stdata_out, dst_out,
               Mwrite_out, Mread_out, RegWrite_out, MtoR_out
    );

    modport slave (
        input  valid_in, pc_in, gprA_in, gprB_in, ext_in, shamt_in, rd_in, rt_in,
               ALUop_in, ALUsrc_in, AluShift_in, RegDst_in, Branch_in, nbranch_in,
               Mwrite_in, Mread_in, RegWrite_in, MtoR_in,
        output stall, do_flush, br_target, res_out, stdata_out, dst_out,
               Mwrite_out, Mread_out, RegWrite_out, MtoR_out
    );

endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide with HI/LO: one shift-add or restoring-divide bit per cycle.
module ex_muldiv_unit #(
    parameter int XLEN     = pipe_pkg::XLEN,
    parameter int MD_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  pipe_pkg::alu_op_t op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              busy,
    output logic [XLEN-1:0]   hi,
    output logic [XLEN-1:0]   lo
);
    import pipe_pkg::*;

    localparam int CW = $clog2(MD_STEPS);

    md_state_t         state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] step_acc;
    logic [XLEN-1:0]   dvsr;
    logic [XLEN-1:0]   dvnd;
    logic [XLEN:0]     trial;
    logic [XLEN:0]     mul_sum;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;
    logic              div0;
    logic              sgn;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    // Sign correction of the unsigned magnitude result, plus divide-by-zero override.
    function automatic logic [2*XLEN-1:0] md_finish(
        input logic [2*XLEN-1:0] r_acc,
        input logic              f_div,
        input logic              f_negq,
        input logic              f_negr,
        input logic              f_div0,
        input logic [XLEN-1:0]   f_dvnd
    );
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        if (!f_div)
            return f_negq ? -r_acc : r_acc;
        if (f_div0)
            return {f_dvnd, {XLEN{1'b1}}};
        q = f_negq ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        r = f_negr ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        return {r, q};
    endfunction

    assign sgn   = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag = (sgn && a[XLEN-1]) ? -a : a;
    assign b_mag = (sgn && b[XLEN-1]) ? -b : b;
    assign busy  = (state == MD_BUSY);

    // acc holds {partial product, multiplier} for multiply, {remainder, quotient} for divide.
    always_comb begin
        step_acc = acc;
        trial    = '0;
        mul_sum  = '0;
        if (is_div) begin
            trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, dvsr};
            if (!trial[XLEN])
                step_acc = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                step_acc = {acc[2*XLEN-2:0], 1'b0};
        end else begin
            mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvsr} : '0);
            step_acc = {mul_sum, acc[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            acc    <= '0;
            dvsr   <= '0;
            dvnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state  <= MD_BUSY;
                                cnt    <= '0;
                                is_div <= (op == OP_DIV) || (op == OP_DIVU);
                                neg_q  <= sgn && (a[XLEN-1] ^ b[XLEN-1]);
                                neg_r  <= sgn && a[XLEN-1];
                                div0   <= (b == '0);
                                dvnd   <= a;
                                if ((op == OP_DIV) || (op == OP_DIVU)) begin
                                    dvsr <= b_mag;
                                    acc  <= {{XLEN{1'b0}}, a_mag};
                                end else begin
                                    dvsr <= a_mag;
                                    acc  <= {{XLEN{1'b0}}, b_mag};
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MD_BUSY: begin
                    acc <= step_acc;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MD_STEPS - 1)) begin
                        {hi, lo} <= md_finish(step_acc, is_div, neg_q, neg_r, div0, dvnd);
                        state    <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution and EX/MEM register; HI/LO unit built when
// EX_MULDIV_EN is defined, otherwise HI/LO opcodes become bubbles and stall is 0.
module ex_stage #(
    parameter int XLEN     = pipe_pkg::XLEN,
    parameter int MD_STEPS = 32
) (
    input logic       clk,
    input logic       rst_n,
    ex_stage_if.slave bus
);
    import pipe_pkg::*;

    localparam int SHW = $clog2(XLEN);

    alu_op_t                op;
    logic [XLEN-1:0]        opa;
    logic [XLEN-1:0]        opb;
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SHW-1:0]         amt;
    logic [XLEN-1:0]        alu_res;
    logic [XLEN-1:0]        hi;
    logic [XLEN-1:0]        lo;
    logic                   stall;
    logic                   issue;
    logic                   load;
    logic                   writes_reg;

    logic [XLEN-1:0]        res_p1;
    logic [XLEN-1:0]        st_p1;
    logic [4:0]             dst_p1;
    logic                   mw_p1;
    logic                   mr_p1;
    logic                   rw_p1;
    logic                   mt_p1;

    assign op  = bus.ALUop_in;
    assign opa = bus.AluShift_in ? {{(XLEN-5){1'b0}}, bus.shamt_in} : bus.gprA_in;
    assign opb = bus.ALUsrc_in ? bus.ext_in : bus.gprB_in;
    assign sa  = opa;
    assign sb  = opb;
    assign amt = opa[SHW-1:0];

`ifdef EX_MULDIV_EN
    logic md_busy;
    logic md_start;

    assign stall    = bus.valid_in & md_busy & is_hilo_op(op);
    assign md_start = issue & is_md_issue(op);
    assign load     = issue;

    ex_muldiv_unit #(
        .XLEN     (XLEN),
        .MD_STEPS (MD_STEPS)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .op    (op),
        .a     (bus.gprA_in),
        .b     (bus.gprB_in),
        .busy  (md_busy),
        .hi    (hi),
        .lo    (lo)
    );
`else
    assign stall = 1'b0;
    assign hi    = '0;
    assign lo    = '0;
    assign load  = issue & ~is_hilo_op(op);
`endif

    assign issue         = bus.valid_in & ~stall;
    assign bus.stall     = stall;
    assign bus.do_flush  = issue & ((bus.Branch_in & (opa == opb)) |
                                    (bus.nbranch_in & (opa != opb)));
    assign bus.br_target = bus.pc_in + (bus.ext_in << 2);
    assign writes_reg    = bus.RegWrite_in & ~bus.Branch_in & ~bus.nbranch_in & ~is_md_issue(op);

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD, OP_ADDU:  alu_res = opa + opb;
            OP_SUB, OP_SUBU:  alu_res = opa - opb;
            OP_AND:           alu_res = opa & opb;
            OP_OR:            alu_res = opa | opb;
            OP_XOR:           alu_res = opa ^ opb;
            OP_NOR:           alu_res = ~(opa | opb);
            OP_SLT:           alu_res = {{(XLEN-1){1'b0}}, (sa < sb)};
            OP_SLTU:          alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
            OP_SLL, OP_SLLV:  alu_res = opb << amt;
            OP_SRL, OP_SRLV:  alu_res = opb >> amt;
            OP_SRA, OP_SRAV:  alu_res = sb >>> amt;
            OP_LUI:           alu_res = bus.ext_in << 16;
            OP_MFHI:          alu_res = hi;
            OP_MFLO:          alu_res = lo;
            default:          alu_res = '0;
        endcase
    end

    // EX/MEM boundary: a bubble or stalled cycle loads all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1 <= '0;
            st_p1  <= '0;
            dst_p1 <= '0;
            mw_p1  <= 1'b0;
            mr_p1  <= 1'b0;
            rw_p1  <= 1'b0;
            mt_p1  <= 1'b0;
        end else if (load) begin
            res_p1 <= alu_res;
            st_p1  <= bus.gprB_in;
            dst_p1 <= bus.RegDst_in ? bus.rd_in : bus.rt_in;
            mw_p1  <= bus.Mwrite_in;
            mr_p1  <= bus.Mread_in;
            rw_p1  <= writes_reg;
            mt_p1  <= bus.MtoR_in;
        end else begin
            res_p1 <= '0;
            st_p1  <= '0;
            dst_p1 <= '0;
            mw_p1  <= 1'b0;
            mr_p1  <= 1'b0;
            rw_p1  <= 1'b0;
            mt_p1  <= 1'b0;
        end
    end

    assign bus.res_out      = res_p1;
    assign bus.stdata_out   = st_p1;
    assign bus.dst_out      = dst_p1;
    assign bus.Mwrite_out   = mw_p1;
    assign bus.Mread_out    = mr_p1;
    assign bus.RegWrite_out = rw_p1;
    assign bus.MtoR_out     = mt_p1;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage; HI/LO tests are selected by EX_MULDIV_EN.
module tb_ex_stage;
    import pipe_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] st;
        logic [4:0]  dst;
        logic        mw;
        logic        mr;
        logic        rw;
        logic        mt;
    } exp_t;

    typedef struct packed {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ext;
        logic [4:0]  sh;
        logic        src;
        logic        shf;
        logic [31:0] res;
    } alu_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    ex_stage_if bus();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t mk(input logic [31:0] r, input logic [31:0] s, input logic [4:0] d,
                                input logic mw, input logic mr, input logic rw, input logic mt);
        exp_t e;
        e.res = r; e.st = s; e.dst = d; e.mw = mw; e.mr = mr; e.rw = rw; e.mt = mt;
        return e;
    endfunction

    function automatic exp_t sample();
        return mk(bus.res_out, bus.stdata_out, bus.dst_out,
                  bus.Mwrite_out, bus.Mread_out, bus.RegWrite_out, bus.MtoR_out);
    endfunction

    task automatic clear_in();
        bus.valid_in = 1'b0; bus.pc_in = '0; bus.gprA_in = '0; bus.gprB_in = '0;
        bus.ext_in = '0; bus.shamt_in = '0; bus.rd_in = '0; bus.rt_in = '0;
        bus.ALUop_in = OP_ADD; bus.ALUsrc_in = 1'b0; bus.AluShift_in = 1'b0;
        bus.RegDst_in = 1'b0; bus.Branch_in = 1'b0; bus.nbranch_in = 1'b0;
        bus.Mwrite_in = 1'b0; bus.Mread_in = 1'b0; bus.RegWrite_in = 1'b0; bus.MtoR_in = 1'b0;
    endtask

    // Advance one clock and pair the DUT output with the oldest expectation.
    task automatic step(output exp_t e, output exp_t act);
        @(posedge clk);
        #1;
        act = sample();
        if (sbq.size() == 0) e = '1;
        else e = sbq.pop_front();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.stall && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        exp_t act;
        clear_in();
        bus.valid_in = 1'b1; bus.gprA_in = 32'd1; bus.gprB_in = 32'd2; bus.RegWrite_in = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        act = sample();
        checks++;
        if (act !== '0) $display("FAIL reset_outputs: got %h want 0", act);
        else passed++;
        checks++;
        if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall);
        else passed++;
        rst_n = 1'b1;
        clear_in();
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu();
        alu_vec_t v[17];
        exp_t e, act;
        v = '{
            '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h0, 5'd0, 1'b0, 1'b0, 32'h80000000},
            '{OP_SUB,  32'h00000000, 32'h00000001, 32'h0, 5'd0, 1'b0, 1'b0, 32'hFFFFFFFF},
            '{OP_SUBU, 32'h00000005, 32'h00000007, 32'h0, 5'd0, 1'b0, 1'b0, 32'hFFFFFFFE},
            '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd0, 1'b0, 1'b0, 32'hF000F000},
            '{OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd0, 1'b0, 1'b0, 32'hFFF0FFF0},
            '{OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0FF00FF0},
            '{OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd0, 1'b0, 1'b0, 32'h000F000F},
            '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h0, 5'd0, 1'b0, 1'b0, 32'h00000001},
            '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h0, 5'd0, 1'b0, 1'b0, 32'h00000000},
            '{OP_SLL,  32'h0000DEAD, 32'h00000F01, 32'h0, 5'd4, 1'b0, 1'b1, 32'h0000F010},
            '{OP_SRL,  32'h0000DEAD, 32'hFFFFFFFF, 32'h0, 5'd31, 1'b0, 1'b1, 32'h00000001},
            '{OP_SRA,  32'h0000DEAD, 32'h80000000, 32'h0, 5'd4, 1'b0, 1'b1, 32'hF8000000},
            '{OP_SLLV, 32'h00000024, 32'h00000001, 32'h0, 5'd0, 1'b0, 1'b0, 32'h00000010},
            '{OP_SRLV, 32'h00000021, 32'h80000000, 32'h0, 5'd0, 1'b0, 1'b0, 32'h40000000},
            '{OP_SRAV, 32'h00000001, 32'h80000001, 32'h0, 5'd0, 1'b0, 1'b0, 32'hC0000000},
            '{OP_LUI,  32'h00000000, 32'h00000000, 32'h00001234, 5'd0, 1'b1, 1'b0, 32'h12340000},
            '{OP_ADDU, 32'h0000000A, 32'h00000063, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b0, 32'h00000009}
        };
        for (int i = 0; i < 17; i++) begin
            clear_in();
            bus.valid_in = 1'b1; bus.ALUop_in = v[i].op; bus.gprA_in = v[i].a; bus.gprB_in = v[i].b;
            bus.ext_in = v[i].ext; bus.shamt_in = v[i].sh; bus.ALUsrc_in = v[i].src;
            bus.AluShift_in = v[i].shf; bus.RegDst_in = 1'b1; bus.rd_in = 5'd3; bus.rt_in = 5'd7;
            bus.RegWrite_in = 1'b1;
            sbq.push_back(mk(v[i].res, v[i].b, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0));
            step(e, act);
            checks++;
            if (act !== e) $display("FAIL alu%0d: got %h want %h", i, act, e);
            else passed++;
        end
    endtask

    task automatic test_branch();
        exp_t e, act;
        logic [31:0] a_t[5] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5};
        logic [31:0] b_t[5] = '{32'd6, 32'd5, 32'd6, 32'd5, 32'd5};
        logic        beq_t[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        v_t[5]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        fl_t[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            clear_in();
            bus.valid_in = v_t[i]; bus.ALUop_in = OP_SUBU; bus.gprA_in = a_t[i]; bus.gprB_in = b_t[i];
            bus.pc_in = 32'h100; bus.ext_in = 32'd3; bus.Branch_in = beq_t[i]; bus.nbranch_in = ~beq_t[i];
            bus.RegWrite_in = 1'b1; bus.RegDst_in = 1'b1; bus.rd_in = 5'd9;
            #1;
            checks++;
            if (bus.do_flush !== fl_t[i]) $display("FAIL flush%0d: got %b want %b", i, bus.do_flush, fl_t[i]);
            else passed++;
            if (i == 0) begin
                checks++;
                if (bus.br_target !== 32'h10C) $display("FAIL br_target: got %h want 0000010c", bus.br_target);
                else passed++;
            end
            if (v_t[i]) sbq.push_back(mk(a_t[i] - b_t[i], b_t[i], 5'd9, 1'b0, 1'b0, 1'b0, 1'b0));
            else sbq.push_back('0);
            step(e, act);
            checks++;
            if (act !== e) $display("FAIL branch_out%0d: got %h want %h", i, act, e);
            else passed++;
        end
    endtask

    task automatic test_bubble_mem();
        exp_t e, act;
        clear_in();
        bus.ALUop_in = OP_ADD; bus.gprA_in = 32'd4; bus.gprB_in = 32'd5; bus.RegWrite_in = 1'b1;
        bus.Mwrite_in = 1'b1; bus.RegDst_in = 1'b1; bus.rd_in = 5'd8;
        sbq.push_back('0);
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL bubble: got %h want %h", act, e);
        else passed++;
        clear_in();
        bus.valid_in = 1'b1; bus.ALUop_in = OP_ADD; bus.gprA_in = 32'h1000; bus.ext_in = 32'd8;
        bus.ALUsrc_in = 1'b1; bus.gprB_in = 32'hCAFEBABE; bus.Mwrite_in = 1'b1; bus.rt_in = 5'd4;
        sbq.push_back(mk(32'h1008, 32'hCAFEBABE, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL store: got %h want %h", act, e);
        else passed++;
        clear_in();
        bus.valid_in = 1'b1; bus.ALUop_in = OP_ADD; bus.gprA_in = 32'h2000; bus.ext_in = 32'hFFFFFFFC;
        bus.ALUsrc_in = 1'b1; bus.gprB_in = 32'h11; bus.Mread_in = 1'b1; bus.MtoR_in = 1'b1;
        bus.RegWrite_in = 1'b1; bus.rt_in = 5'd5;
        sbq.push_back(mk(32'h1FFC, 32'h11, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL load: got %h want %h", act, e);
        else passed++;
    endtask

`ifdef EX_MULDIV_EN
    task automatic run_md(input alu_op_t mop, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi_exp, input logic [31:0] lo_exp, input string nm);
        exp_t e, act;
        int   n;
        clear_in();
        bus.valid_in = 1'b1; bus.ALUop_in = mop; bus.gprA_in = a; bus.gprB_in = b; bus.RegWrite_in = 1'b1;
        sbq.push_back(mk(32'h0, b, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL %s_issue: got %h want %h", nm, act, e);
        else passed++;
        clear_in();
        bus.valid_in = 1'b1; bus.ALUop_in = OP_MFLO; bus.RegWrite_in = 1'b1; bus.RegDst_in = 1'b1; bus.rd_in = 5'd2;
        #1;
        wait_idle(n);
        checks++;
        if (n >= 100) $display("FAIL %s_timeout: stall still %b after %0d cycles, want 0", nm, bus.stall, n);
        else passed++;
        sbq.push_back(mk(lo_exp, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL %s_lo: got %h want %h", nm, act, e);
        else passed++;
        bus.ALUop_in = OP_MFHI; bus.rd_in = 5'd3;
        sbq.push_back(mk(hi_exp, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL %s_hi: got %h want %h", nm, act, e);
        else passed++;
    endtask

    task automatic test_mult();
        exp_t e, act;
        int   n;
        clear_in();
        bus.valid_in = 1'b1; bus.ALUop_in = OP_MULT; bus.gprA_in = 32'hFFFFFFFF; bus.gprB_in = 32'd2;
        sbq.push_back(mk(32'h0, 32'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL mult_issue: got %h want %h", act, e);
        else passed++;
        clear_in();
        bus.valid_in = 1'b1; bus.ALUop_in = OP_MFLO; bus.RegWrite_in = 1'b1; bus.RegDst_in = 1'b1; bus.rd_in = 5'd2;
        #1;
        checks++;
        if (bus.stall !== 1'b1) $display("FAIL mult_stall_on: got %b want 1", bus.stall);
        else passed++;
        wait_idle(n);
        checks++;
        if (n != 32) $display("FAIL mult_stall_len: got %0d want 32", n);
        else passed++;
        sbq.push_back(mk(32'hFFFFFFFE, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL mult_lo: got %h want %h", act, e);
        else passed++;
        bus.ALUop_in = OP_MFHI;
        sbq.push_back(mk(32'hFFFFFFFF, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL mult_hi: got %h want %h", act, e);
        else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e, act;
        int   n;
        clear_in();
        bus.valid_in = 1'b1; bus.ALUop_in = OP_MULTU; bus.gprA_in = 32'hFFFFFFFF; bus.gprB_in = 32'd2;
        sbq.push_back(mk(32'h0, 32'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL multu_issue: got %h want %h", act, e);
        else passed++;
        clear_in();
        bus.valid_in = 1'b1; bus.ALUop_in = OP_ADD; bus.gprA_in = 32'd1; bus.gprB_in = 32'd2;
        bus.RegWrite_in = 1'b1; bus.RegDst_in = 1'b1; bus.rd_in = 5'd4;
        #1;
        checks++;
        if (bus.stall !== 1'b0) $display("FAIL busy_add_stall: got %b want 0", bus.stall);
        else passed++;
        sbq.push_back(mk(32'd3, 32'd2, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL busy_add: got %h want %h", act, e);
        else passed++;
        clear_in();
        bus.valid_in = 1'b1; bus.ALUop_in = OP_MFHI; bus.RegWrite_in = 1'b1; bus.RegDst_in = 1'b1; bus.rd_in = 5'd6;
        #1;
        wait_idle(n);
        checks++;
        if (n != 31) $display("FAIL multu_stall_len: got %0d want 31", n);
        else passed++;
        sbq.push_back(mk(32'h1, 32'h0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL multu_hi: got %h want %h", act, e);
        else passed++;
    endtask

    task automatic test_div();
        run_md(OP_DIV,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, "div0");
        run_md(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "divneg");
        run_md(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, "divovf");
        run_md(OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       "divu");
        run_md(OP_MULT, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "multneg");
    endtask

    task automatic test_reset_mid_div();
        exp_t e, act;
        clear_in();
        bus.valid_in = 1'b1; bus.ALUop_in = OP_DIV; bus.gprA_in = 32'd100; bus.gprB_in = 32'd3;
        sbq.push_back(mk(32'h0, 32'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL rdiv_issue: got %h want %h", act, e);
        else passed++;
        clear_in();
        bus.valid_in = 1'b1; bus.ALUop_in = OP_MFHI; bus.RegWrite_in = 1'b1; bus.RegDst_in = 1'b1; bus.rd_in = 5'd7;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) $display("FAIL rdiv_stall: got %b want 0", bus.stall);
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbq.push_back(mk(32'h0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL rdiv_hi: got %h want %h", act, e);
        else passed++;
        bus.ALUop_in = OP_MFLO;
        sbq.push_back(mk(32'h0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0));
        step(e, act);
        checks++;
        if (act !== e) $display("FAIL rdiv_lo: got %h want %h", act, e);
        else passed++;
    endtask
`else
    task automatic test_hilo_disabled();
        exp_t    e, act;
        alu_op_t ops[4] = '{OP_MULT, OP_MFHI, OP_MTLO, OP_MFLO};
        logic    seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            clear_in();
            bus.valid_in = 1'b1; bus.ALUop_in = ops[i]; bus.gprA_in = 32'hFFFFFFFF; bus.gprB_in = 32'd2;
            bus.RegWrite_in = 1'b1; bus.RegDst_in = 1'b1; bus.rd_in = 5'd2;
            #1;
            checks++;
            if (bus.stall !== 1'b0) $display("FAIL nomd_stall%0d: got %b want 0", i, bus.stall);
            else passed++;
            sbq.push_back('0);
            step(e, act);
            checks++;
            if (act !== e) $display("FAIL nomd_bubble%0d: got %h want %h", i, act, e);
            else passed++;
        end
        bus.ALUop_in = OP_MFHI;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.stall !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL nomd_stall_window: got %b want 0", seen);
        else passed++;
    endtask
`endif

    initial begin
        clear_in();
        test_reset();
        test_alu();
        test_branch();
        test_bubble_mem();
`ifdef EX_MULDIV_EN
        test_mult();
        test_back_to_back();
        test_div();
        test_reset_mid_div();
`else
        test_hilo_disabled();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
